// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store split unit: FSM state
// encoding, RV32I load/store funct3 codes and small decode functions.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        LOAD_LO,
        LOAD_HI,
        STORE_B,
        DONE
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Number of bytes moved by an access of the given funct3.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores only exist as SB/SH/SW; loads reject the three unused codes.
    function automatic logic is_unsupported(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 != SB) && (funct3 != SH) && (funct3 != SW);
        end
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    // True when an access starting at this byte offset runs past the word.
    function automatic logic crosses_word(input logic [1:0] offset, input logic [2:0] funct3);
        return ({1'b0, offset} + access_bytes(funct3)) > 3'd4;
    endfunction

    // True when a store cannot be issued to memory as a single access.
    function automatic logic store_misaligned(input logic [1:0] offset, input logic [2:0] funct3);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_split_if.sv
// Request/response and data-memory bundle of the load/store split unit.
// The slave modport is the LSU itself; master is the execute stage plus
// the data memory that surround it.
interface lsu_split_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic                  dm_MemRead;
    logic                  dm_MemWrite;
    logic [DM_ADDRESS-1:0] dm_a;
    logic [DATA_W-1:0]     dm_wd;
    logic [2:0]            dm_funct3;
    logic [DATA_W-1:0]     dm_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_funct3
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_funct3
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the addressed bytes out of a little-endian
// pair of words and sign/zero extends them according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);
    logic [31:0] shifted;

    // Shift the word pair down to the access offset, then extend.
    always_comb begin
        shifted = 32'({hi_word, lo_word} >> {offset, 3'b000});
        case (funct3)
            LB:      rdata = {{24{shifted[7]}}, shifted[7:0]};
            LH:      rdata = {{16{shifted[15]}}, shifted[15:0]};
            LW:      rdata = shifted;
            LBU:     rdata = {24'h0, shifted[7:0]};
            LHU:     rdata = {16'h0, shifted[15:0]};
            default: rdata = 32'h0;
        endcase
    end
endmodule

// File: rtl/lsu_split.sv
// Load/store unit front end. Accepts one request at a time and turns
// misaligned accesses into sequences of aligned memory operations: loads
// always read whole words (one or two), misaligned stores become byte
// stores. All outputs come straight from flops.
module lsu_split
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_split_if.slave bus
);
    localparam int WIDX = DM_ADDRESS - 2;

    lsu_state_e            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     lo_word_q, lo_word_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DM_ADDRESS-1:0] dm_a_q, dm_a_d;
    logic [DATA_W-1:0]     dm_wd_q, dm_wd_d;
    logic [2:0]            dm_funct3_q, dm_funct3_d;

    logic [DATA_W-1:0]     align_lo;
    logic [DATA_W-1:0]     align_rdata;
    logic [1:0]            last_byte;
    logic [7:0]            store_byte;
    logic [WIDX-1:0]       next_word;

    // In LOAD_HI the low word was latched a cycle earlier; otherwise the
    // single word being read right now supplies every byte.
    assign align_lo  = (state_q == LOAD_HI) ? lo_word_q : bus.dm_rd;
    assign last_byte = 2'(access_bytes(funct3_q) - 3'd1);

    lsu_load_align u_align (
        .lo_word (align_lo),
        .hi_word (bus.dm_rd),
        .offset  (addr_q[1:0]),
        .funct3  (funct3_q),
        .rdata   (align_rdata)
    );

    // Sequencing: next state, request capture, byte counter and response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_word_d    = lo_word_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = 2'd0;
                    if (is_unsupported(bus.req_we, bus.req_funct3)) begin
                        state_d    = DONE;
                        resp_err_d = 1'b1;
                    end else if (!bus.req_we) begin
                        state_d = crosses_word(bus.req_addr[1:0], bus.req_funct3) ? LOAD_LO : ACCESS;
                    end else begin
                        state_d = store_misaligned(bus.req_addr[1:0], bus.req_funct3) ? STORE_B : ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!we_q) begin
                    resp_rdata_d = align_rdata;
                end
            end
            LOAD_LO: begin
                lo_word_d = bus.dm_rd;
                state_d   = LOAD_HI;
            end
            LOAD_HI: begin
                state_d      = DONE;
                resp_rdata_d = align_rdata;
            end
            STORE_B: begin
                if (cnt_q == last_byte) begin
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        resp_valid_d = (state_d == DONE);
        req_ready_d  = (state_d == IDLE);
    end

    // Memory strobes for the cycle about to start, so they can be registered.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        dm_a_d      = '0;
        dm_wd_d     = '0;
        dm_funct3_d = 3'b000;
        store_byte  = 8'(wdata_d >> {cnt_d, 3'b000});
        next_word   = addr_d[DM_ADDRESS-1:2] + WIDX'(1);
        case (state_d)
            ACCESS: begin
                if (we_d) begin
                    mem_write_d = 1'b1;
                    dm_a_d      = addr_d;
                    dm_wd_d     = wdata_d;
                    dm_funct3_d = funct3_d;
                end else begin
                    mem_read_d  = 1'b1;
                    dm_a_d      = {addr_d[DM_ADDRESS-1:2], 2'b00};
                    dm_funct3_d = LW;
                end
            end
            LOAD_LO: begin
                mem_read_d  = 1'b1;
                dm_a_d      = {addr_d[DM_ADDRESS-1:2], 2'b00};
                dm_funct3_d = LW;
            end
            LOAD_HI: begin
                mem_read_d  = 1'b1;
                dm_a_d      = {next_word, 2'b00};
                dm_funct3_d = LW;
            end
            STORE_B: begin
                mem_write_d = 1'b1;
                dm_a_d      = addr_d + DM_ADDRESS'(cnt_d);
                dm_wd_d     = DATA_W'(store_byte);
                dm_funct3_d = SB;
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_word_q    <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            dm_a_q       <= '0;
            dm_wd_q      <= '0;
            dm_funct3_q  <= 3'b000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_word_q    <= lo_word_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            dm_a_q       <= dm_a_d;
            dm_wd_q      <= dm_wd_d;
            dm_funct3_q  <= dm_funct3_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.dm_MemRead  = mem_read_q;
    assign bus.dm_MemWrite = mem_write_q;
    assign bus.dm_a        = dm_a_q;
    assign bus.dm_wd       = dm_wd_q;
    assign bus.dm_funct3   = dm_funct3_q;
endmodule

// File: tb/tb_lsu_split.sv
// Testbench for lsu_split: byte-array data memory, scoreboard of expected
// responses with latency, table of load/store vectors, and hand-written
// sequences for strobe ordering, wrap-around and mid-operation reset.
module tb_lsu_split;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   lsu_split_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

   lsu_split #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int ncyc  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [8:0]  a;
      logic [31:0] wd;
      logic [2:0]  f3;
   } strobe_t;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   exp_t    exp_q[$];
   int      acc_q[$];
   strobe_t slog[$];
   vec_t    vecs[$];
   exp_t    mon_e;
   int      mon_acc;

   logic [7:0]  mem_b [512] = '{default: 8'h00};
   logic        bd_we  = 1'b0;
   logic [6:0]  bd_idx = '0;
   logic [31:0] bd_val = '0;

   // Combinational word read, valid in the same cycle as dm_MemRead
   always_comb begin
      bus.dm_rd = 32'h0;
      if (bus.dm_MemRead) begin
         bus.dm_rd = {mem_b[{bus.dm_a[8:2], 2'b11}], mem_b[{bus.dm_a[8:2], 2'b10}],
                      mem_b[{bus.dm_a[8:2], 2'b01}], mem_b[{bus.dm_a[8:2], 2'b00}]};
      end
   end

   // Memory writes: back-door preload from the test, otherwise DUT stores
   always @(posedge clk) begin
      if (bd_we) begin
         for (int i = 0; i < 4; i++) mem_b[{bd_idx, 2'(i)}] <= bd_val[8*i +: 8];
      end else if (bus.dm_MemWrite) begin
         case (bus.dm_funct3)
            SB: mem_b[bus.dm_a] <= bus.dm_wd[7:0];
            SH: begin
               mem_b[bus.dm_a]         <= bus.dm_wd[7:0];
               mem_b[bus.dm_a + 9'd1]  <= bus.dm_wd[15:8];
            end
            SW: begin
               for (int i = 0; i < 4; i++) mem_b[bus.dm_a + 9'(i)] <= bus.dm_wd[8*i +: 8];
            end
            default: begin
            end
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: bus invariants, strobe log, accept times and scoreboard pops
   always @(negedge clk) begin
      checkOutput("bus_quiet_rules",
         32'(!(bus.dm_MemRead && bus.dm_MemWrite) &&
             (bus.dm_MemRead || bus.dm_MemWrite ||
              (bus.dm_a == 9'h0 && bus.dm_wd == 32'h0 && bus.dm_funct3 == 3'b000)) &&
             (bus.resp_valid || (bus.resp_rdata == 32'h0 && !bus.resp_err))),
         32'd1);
      if (bus.dm_MemRead || bus.dm_MemWrite)
         slog.push_back('{bus.dm_MemRead, bus.dm_MemWrite, bus.dm_a, bus.dm_wd, bus.dm_funct3});
      if (rst_n && bus.req_valid && bus.req_ready) acc_q.push_back(ncyc);
      if (bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
         end else begin
            mon_e   = exp_q.pop_front();
            mon_acc = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
            checkOutput({mon_e.name, "_rdata"}, bus.resp_rdata, mon_e.rdata);
            checkOutput({mon_e.name, "_err"}, 32'(bus.resp_err), 32'(mon_e.err));
            checkOutput({mon_e.name, "_latency"}, 32'(ncyc - mon_acc), 32'(mon_e.lat));
         end
      end
      ncyc++;
   end

   task automatic setWord(input logic [6:0] idx, input logic [31:0] val);
      @(posedge clk);
      #1;
      bd_idx = idx;
      bd_val = val;
      bd_we  = 1'b1;
      @(posedge clk);
      #1;
      bd_we  = 1'b0;
   endtask

   task automatic driveReq(input logic we, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wdata);
      int guard;
      @(posedge clk);
      #1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL accept_timeout: got req_ready=0 for 20 cycles, expected 1");
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
   endtask

   task automatic waitResp(input string name);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s_timeout: got no resp_valid in 30 cycles, expected one", name);
         exp_q.delete();
         acc_q.delete();
      end
      @(posedge clk);
   endtask

   task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                                input logic [8:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      exp_q.push_back('{exp_rdata, exp_err, exp_lat, name});
      driveReq(we, f3, addr, wdata);
      waitResp(name);
   endtask

   task automatic checkStrobe(input string name, input int idx, input logic rd, input logic wr,
                              input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3);
      if (idx >= slog.size()) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s: got %0d strobes, expected at least %0d", name, slog.size(), idx + 1);
      end else begin
         checkOutput({name, "_kind_addr_f3"}, 32'({slog[idx].rd, slog[idx].wr, slog[idx].f3, slog[idx].a}),
                     32'({rd, wr, f3, a}));
         checkOutput({name, "_wd"}, slog[idx].wd, wd);
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus
   initial begin
      int guard;
      logic found;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("reset_strobes", 32'({bus.dm_MemRead, bus.dm_MemWrite}), 32'd0);
      checkOutput("reset_dm_a", 32'(bus.dm_a), 32'd0);
      checkOutput("reset_resp_rdata", bus.resp_rdata, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);

      setWord(7'd8,   32'h8899AABB);
      setWord(7'd9,   32'h11F2E3D4);
      setWord(7'd127, 32'hC0FFEE01);
      setWord(7'd0,   32'h76543210);

      vecs.push_back('{"lw_aligned",      1'b0, LW,     9'h020, 32'h0,        32'h8899AABB, 1'b0, 2});
      vecs.push_back('{"lb_neg",          1'b0, LB,     9'h021, 32'h0,        32'hFFFFFFAA, 1'b0, 2});
      vecs.push_back('{"lbu_top",         1'b0, LBU,    9'h023, 32'h0,        32'h00000088, 1'b0, 2});
      vecs.push_back('{"lh_aligned_neg",  1'b0, LH,     9'h022, 32'h0,        32'hFFFF8899, 1'b0, 2});
      vecs.push_back('{"lhu_inword_odd",  1'b0, LHU,    9'h021, 32'h0,        32'h000099AA, 1'b0, 2});
      vecs.push_back('{"lh_span",         1'b0, LH,     9'h023, 32'h0,        32'hFFFFD488, 1'b0, 3});
      vecs.push_back('{"lw_span",         1'b0, LW,     9'h022, 32'h0,        32'hE3D48899, 1'b0, 3});
      vecs.push_back('{"lw_span_wrap",    1'b0, LW,     9'h1FD, 32'h0,        32'h10C0FFEE, 1'b0, 3});
      vecs.push_back('{"lhu_span_wrap",   1'b0, LHU,    9'h1FF, 32'h0,        32'h000010C0, 1'b0, 3});
      vecs.push_back('{"load_f3_110",     1'b0, 3'b110, 9'h020, 32'h0,        32'h00000000, 1'b1, 1});
      vecs.push_back('{"load_f3_111",     1'b0, 3'b111, 9'h021, 32'h0,        32'h00000000, 1'b1, 1});
      vecs.push_back('{"lb_pos",          1'b0, LB,     9'h027, 32'h0,        32'h00000011, 1'b0, 2});
      vecs.push_back('{"lbu_mid",         1'b0, LBU,    9'h026, 32'h0,        32'h000000F2, 1'b0, 2});
      vecs.push_back('{"sw_aligned",      1'b1, SW,     9'h040, 32'hCAFEBABE, 32'h00000000, 1'b0, 2});
      vecs.push_back('{"sh_misaligned",   1'b1, SH,     9'h043, 32'h0000BEEF, 32'h00000000, 1'b0, 3});
      vecs.push_back('{"lw_after_sh",     1'b0, LW,     9'h040, 32'h0,        32'hEFFEBABE, 1'b0, 2});
      vecs.push_back('{"lbu_sh_hi_byte",  1'b0, LBU,    9'h044, 32'h0,        32'h000000BE, 1'b0, 2});
      vecs.push_back('{"sb_aligned",      1'b1, SB,     9'h045, 32'h12345677, 32'h00000000, 1'b0, 2});
      vecs.push_back('{"sh_aligned",      1'b1, SH,     9'h046, 32'hFFFFA5A5, 32'h00000000, 1'b0, 2});
      vecs.push_back('{"lw_after_sb_sh",  1'b0, LW,     9'h044, 32'h0,        32'hA5A577BE, 1'b0, 2});
      vecs.push_back('{"store_f3_011",    1'b1, 3'b011, 9'h044, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1});
      vecs.push_back('{"lw_after_bad_st", 1'b0, LW,     9'h044, 32'h0,        32'hA5A577BE, 1'b0, 2});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
      end

      // Aligned word load: a single read of word 1
      setWord(7'd1, 32'hDEADBEEF);
      slog.delete();
      applyStimulus("lw_004", 1'b0, LW, 9'h004, 32'h0, 32'hDEADBEEF, 1'b0, 2);
      checkOutput("lw_004_nstrobes", 32'(slog.size()), 32'd1);
      checkStrobe("lw_004_read", 0, 1'b1, 1'b0, 9'h004, 32'h0, LW);

      // Halfword straddling words 0 and 1
      setWord(7'd0, 32'h80000000);
      setWord(7'd1, 32'h00000012);
      slog.delete();
      applyStimulus("lh_003", 1'b0, LH, 9'h003, 32'h0, 32'h00001280, 1'b0, 3);
      checkOutput("lh_003_nstrobes", 32'(slog.size()), 32'd2);
      checkStrobe("lh_003_read0", 0, 1'b1, 1'b0, 9'h000, 32'h0, LW);
      checkStrobe("lh_003_read1", 1, 1'b1, 1'b0, 9'h004, 32'h0, LW);

      // Misaligned word store wrapping past the top, with a request while busy
      slog.delete();
      exp_q.push_back('{32'h0, 1'b0, 5, "sw_1fe"});
      driveReq(1'b1, SW, 9'h1FE, 32'h11223344);
      @(negedge clk);
      checkOutput("busy_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_we     = 1'b0;
      bus.req_funct3 = LW;
      bus.req_addr   = 9'h000;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      waitResp("sw_1fe");
      checkOutput("sw_1fe_nstrobes", 32'(slog.size()), 32'd4);
      checkStrobe("sw_1fe_b0", 0, 1'b0, 1'b1, 9'h1FE, 32'h44, SB);
      checkStrobe("sw_1fe_b1", 1, 1'b0, 1'b1, 9'h1FF, 32'h33, SB);
      checkStrobe("sw_1fe_b2", 2, 1'b0, 1'b1, 9'h000, 32'h22, SB);
      checkStrobe("sw_1fe_b3", 3, 1'b0, 1'b1, 9'h001, 32'h11, SB);

      // Byte loads with zero and sign extension
      setWord(7'd1, 32'h0000F000);
      applyStimulus("lbu_005", 1'b0, LBU, 9'h005, 32'h0, 32'h000000F0, 1'b0, 2);
      applyStimulus("lb_005",  1'b0, LB,  9'h005, 32'h0, 32'hFFFFFFF0, 1'b0, 2);

      // Unsupported funct3: error response with no memory activity
      slog.delete();
      applyStimulus("f3_011", 1'b0, 3'b011, 9'h008, 32'h0, 32'h0, 1'b1, 1);
      checkOutput("f3_011_nstrobes", 32'(slog.size()), 32'd0);

      // Reset while the third byte of a split store is on the bus
      setWord(7'd0, 32'h0);
      setWord(7'd127, 32'h0);
      driveReq(1'b1, SW, 9'h1FE, 32'h11223344);
      found = 1'b0;
      guard = 0;
      while (!found && guard < 20) begin
         @(negedge clk);
         found = bus.dm_MemWrite && (bus.dm_a == 9'h000);
         guard++;
      end
      checkOutput("rst_byte2_seen", 32'(found), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_write", 32'(bus.dm_MemWrite), 32'd0);
      checkOutput("rst_mid_dm_a", 32'(bus.dm_a), 32'd0);
      checkOutput("rst_mid_dm_wd", bus.dm_wd, 32'd0);
      checkOutput("rst_mid_dm_funct3", 32'(bus.dm_funct3), 32'd0);
      checkOutput("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_release_ready", 32'(bus.req_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("rst_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      checkOutput("rst_mem_1fe", 32'(mem_b[9'h1FE]), 32'h44);
      checkOutput("rst_mem_1ff", 32'(mem_b[9'h1FF]), 32'h33);
      checkOutput("rst_mem_000", 32'(mem_b[9'h000]), 32'h00);
      checkOutput("rst_mem_001", 32'(mem_b[9'h001]), 32'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lsu_split.md
LSU_SPLIT -- requirements
Module: lsu_split

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width toward data memory.
REQ-002 Parameter DATA_W, default 32, data width; only 32 supported.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  access request from execute stage.
REQ-006 req_ready  out  1  block idle, can accept a request.
REQ-007 req_we  in  1  store when 1, load when 0.
REQ-008 req_funct3  in  3  RV32I load/store funct3.
REQ-009 req_addr  in  DM_ADDRESS  byte address.
REQ-010 req_wdata  in  DATA_W  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  DATA_W  load result, extended per funct3; 0 for stores.
REQ-013 resp_err  out  1  qualifies resp_valid; unsupported funct3.
REQ-014 dm_MemRead, dm_MemWrite  out  1 each  data-memory strobes.
REQ-015 dm_a  out  DM_ADDRESS  data-memory byte address.
REQ-016 dm_wd  out  DATA_W  data-memory write data.
REQ-017 dm_funct3  out  3  data-memory access size.
REQ-018 dm_rd  in  DATA_W  data-memory read word, valid combinationally in the same cycle as dm_MemRead.

Function
REQ-019 Handshake: request accepted on the rising edge where req_valid and req_ready are both 1; all req_* fields captured then.
REQ-020 req_ready = 1 only in IDLE.
REQ-021 FSM states: IDLE, ACCESS, LOAD_LO, LOAD_HI, STORE_B, DONE.
REQ-022 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-023 IDLE on accept -> ACCESS (aligned, or misaligned load with offset+size<=4), LOAD_LO (load spanning two words), STORE_B (misaligned store), or DONE with resp_err (funct3 011/110/111; no memory strobe).
REQ-024 All loads issue dm_funct3=010 at word address {addr[8:2],2'b00}; lane extraction and sign/zero extension (LB/LH sign, LBU/LHU zero) are done in this block.
REQ-025 Aligned stores pass through unchanged: dm_funct3=req_funct3, dm_a=req_addr, dm_wd=req_wdata.
REQ-026 ACCESS: one strobe cycle -> DONE.
REQ-027 LOAD_LO reads word W, LOAD_HI reads word W+1; word index wraps modulo 2^(DM_ADDRESS-2) (127 -> 0); bytes concatenated little-endian.
REQ-028 STORE_B: 2 (halfword) or 4 (word) SB cycles at consecutive byte addresses, counter 0..n-1; byte address wraps 511 -> 0; last byte -> DONE.
REQ-029 DONE: resp_valid=1 for exactly one cycle, then IDLE.
REQ-030 Latency from accept edge T: aligned/in-word access resp_valid in cycle T+2; spanning load T+3; misaligned SH T+3; misaligned SW T+5; error T+1.
REQ-031 dm_MemRead/dm_MemWrite never both 1; both 0 outside ACCESS, LOAD_LO, LOAD_HI, STORE_B; dm_a, dm_wd, dm_funct3 = 0 when no strobe.
REQ-032 resp_rdata and resp_err hold 0 except in DONE.
REQ-033 req_valid while busy is ignored (req_ready=0); requester holds.

Reset
REQ-034 rst_n=0 forces IDLE, counter 0, captured request 0, all outputs 0 except req_ready=1 once in IDLE.
REQ-035 Reset mid-operation abandons the access; partially written bytes remain in memory; no resp_valid.

Structure
REQ-036 Shared package lsu_pkg holds the FSM state enum and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-037 One sub-module, lsu_load_align: combinational byte-lane select and extension from two words, offset and funct3.

Verification
REQ-038 LW addr 0x004, mem word1=0xDEADBEEF -> one read, resp_rdata=0xDEADBEEF at T+2.
REQ-039 LH addr 0x003, word0=0x80xxxxxx, word1=0xxxxxxx12 -> two reads (0x000, 0x004), resp_rdata=0x00001280 at T+3.
REQ-040 SW addr 0x1FE, wdata 0x11223344 -> SB at 0x1FE, 0x1FF, 0x000, 0x001 with bytes 44,33,22,11; resp_valid at T+5.
REQ-041 LBU addr 0x005 of word 0x0000F000 -> 0x000000F0; LB same address -> 0xFFFFFFF0.
REQ-042 funct3=011 -> no dm strobe, resp_valid and resp_err at T+1.
REQ-043 rst_n low during STORE_B byte 2 -> outputs 0 immediately, req_ready=1 after release, no resp_valid.
